// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding control for the EX stage of a 5-stage pipeline.
// Tracks its own EX/MEM/WB register-tag shadow so the datapath only needs
// to present decode-stage fields. Produces operand-forwarding mux selects,
// load-use stall, branch flush, and saturating debug event counters.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0] SelRegFile = 2'b00;
    localparam logic [1:0] SelMem     = 2'b01;
    localparam logic [1:0] SelWb      = 2'b10;

    // EX shadow keeps source tags because forwarding compares against them.
    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rs1;
    logic [REG_ADDR_W-1:0] r_ex_rs2;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_reg_write;
    logic                  r_ex_mem_read;

    // Past EX only the destination and its write-enable matter; source tags
    // and the load flag would never be read again, so they are not carried.
    logic                  r_mem_valid;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_reg_write;

    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_reg_write;

    logic [CNT_W-1:0]      r_stall_count;
    logic [CNT_W-1:0]      r_flush_count;

    logic                  w_load_use;
    logic                  w_bubble;
    logic                  w_mem_fwd_ok;
    logic                  w_wb_fwd_ok;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // A load in EX whose (non-x0) destination is read by the decoding instruction.
    assign w_load_use = r_ex_valid && r_ex_mem_read && (r_ex_rd != '0) && id_valid &&
                        ((id_rs1 == r_ex_rd) || (id_rs2 == r_ex_rd));

    // EX receives a bubble instead of the decode fields when stalling, flushing or idle.
    assign w_bubble = w_load_use || ex_branch_taken || !id_valid;

    // A stage can supply a forwarded value only if it really writes a non-x0 register.
    assign w_mem_fwd_ok = r_mem_valid && r_mem_reg_write && (r_mem_rd != '0);
    assign w_wb_fwd_ok  = r_wb_valid && r_wb_reg_write && (r_wb_rd != '0);

    // EX shadow stage: capture decode fields or a bubble; freeze while memory is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
        end else if (!mem_busy) begin
            if (w_bubble) begin
                r_ex_valid     <= 1'b0;
                r_ex_rs1       <= '0;
                r_ex_rs2       <= '0;
                r_ex_rd        <= '0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end else begin
                r_ex_valid     <= 1'b1;
                r_ex_rs1       <= id_rs1;
                r_ex_rs2       <= id_rs2;
                r_ex_rd        <= id_rd;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
            end
        end
    end

    // MEM and WB shadow stages shift forward together; freeze while memory is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_reg_write  <= 1'b0;
        end else if (!mem_busy) begin
            r_mem_valid     <= r_ex_valid;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            r_wb_valid      <= r_mem_valid;
            r_wb_rd         <= r_mem_rd;
            r_wb_reg_write  <= r_mem_reg_write;
        end
    end

    // Operand selects: youngest producer (MEM) wins over WB; 2'b11 is never produced.
    always_comb begin
        fwd_a_sel = SelRegFile;
        fwd_b_sel = SelRegFile;
        if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs1)) begin
            fwd_a_sel = SelMem;
        end else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs1)) begin
            fwd_a_sel = SelWb;
        end
        if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs2)) begin
            fwd_b_sel = SelMem;
        end else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs2)) begin
            fwd_b_sel = SelWb;
        end
    end

    // Pipeline control: memory freeze beats branch flush, which beats load-use stall;
    // everything is forced low while reset is asserted.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ex_branch_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (w_load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    // Debug counters: count stall cycles and taken-branch flushes, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (!mem_busy) begin
            if (ex_branch_taken) begin
                if (r_flush_count != '1) begin
                    r_flush_count <= r_flush_count + CntOne;
                end
            end else if (w_load_use) begin
                if (r_stall_count != '1) begin
                    r_stall_count <= r_stall_count + CntOne;
                end
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl. Each scenario task drives a
// short instruction sequence, pushes hand-derived expected outputs into a
// scoreboard queue, and pops/compares them when the outputs are sampled on
// the falling edge.
module tb_hazard_forward_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic       busy;
    } stim_t;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        si;
        logic        sd;
        logic        fi;
        logic        fe;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        ex_branch_taken;
    logic        mem_busy;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int   compared;
    int   mismatched;
    exp_t scoreboard[$];

    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total run time so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t S(input logic v, input int rs1, input int rs2, input int rd,
                                input logic rw, input logic mr, input logic br, input logic busy);
        stim_t s;
        s.v    = v;
        s.rs1  = rs1[4:0];
        s.rs2  = rs2[4:0];
        s.rd   = rd[4:0];
        s.rw   = rw;
        s.mr   = mr;
        s.br   = br;
        s.busy = busy;
        return s;
    endfunction

    function automatic exp_t E(input logic [1:0] fa, input logic [1:0] fb, input logic si,
                               input logic sd, input logic fi, input logic fe,
                               input int sc, input int fc);
        exp_t e;
        e.fa = fa;
        e.fb = fb;
        e.si = si;
        e.sd = sd;
        e.fi = fi;
        e.fe = fe;
        e.sc = sc[15:0];
        e.fc = fc[15:0];
        return e;
    endfunction

    function automatic exp_t observe();
        return {fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex,
                stall_count, flush_count};
    endfunction

    // Drive one decode-stage slot just after the rising edge.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        id_valid        = s.v;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_rd           = s.rd;
        id_reg_write    = s.rw;
        id_mem_read     = s.mr;
        ex_branch_taken = s.br;
        mem_busy        = s.busy;
    endtask

    // Feed empty slots so the shadow pipeline drains to bubbles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(S(0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset();
        exp_t got;
        exp_t want;
        rst_n           = 1'b0;
        id_valid        = 1'b0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_rd           = '0;
        id_reg_write    = 1'b0;
        id_mem_read     = 1'b0;
        ex_branch_taken = 1'b1;
        mem_busy        = 1'b0;
        scoreboard.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        #2;
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL reset_branch: got %h want %h", got, want);
        end
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b1;
        scoreboard.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        #1;
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %h want %h", got, want);
        end
        mem_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(S(0, 0, 0, 0, 0, 0, 0, 0));
        scoreboard.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got %h want %h", got, want);
        end
    endtask

    // add x5 ; sub x6,x5,x7 ; or x10,x5,x6 ; nop
    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(S(1, 1, 2, 5, 1, 0, 0, 0));  ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        st.push_back(S(1, 5, 7, 6, 1, 0, 0, 0));  ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        st.push_back(S(1, 5, 6, 10, 1, 0, 0, 0)); ex.push_back(E(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0));  ex.push_back(E(2'b10, 2'b01, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            scoreboard.push_back(ex[i]);
            @(negedge clk);
            got  = observe();
            want = scoreboard.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL back_to_back step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    // lw x8 ; add x9,x8,x8 (held one cycle by the stall) ; nop
    task automatic test_load_use();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(S(1, 1, 0, 8, 1, 1, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        st.push_back(S(1, 8, 8, 9, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 1, 1, 0, 1, 0, 0));
        st.push_back(S(1, 8, 8, 9, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(2'b10, 2'b10, 0, 0, 0, 0, 1, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            scoreboard.push_back(ex[i]);
            @(negedge clk);
            got  = observe();
            want = scoreboard.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL load_use step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    // addi x3 ; addi x3 ; sub x4,x3,x3 -> x3 live in both MEM and WB
    task automatic test_double_match();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(S(1, 0, 0, 3, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(1, 0, 0, 3, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(1, 3, 3, 4, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(2'b01, 2'b01, 0, 0, 0, 0, 1, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            scoreboard.push_back(ex[i]);
            @(negedge clk);
            got  = observe();
            want = scoreboard.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL double_match step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    // addi x0 ; add x11,x0,x0 ; nop ; lw x0 ; add x12,x0,x0
    task automatic test_x0();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(S(1, 1, 0, 0, 1, 0, 0, 0));  ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(1, 0, 0, 11, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0));  ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(1, 2, 0, 0, 1, 1, 0, 0));  ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(1, 0, 0, 12, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0));  ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            scoreboard.push_back(ex[i]);
            @(negedge clk);
            got  = observe();
            want = scoreboard.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL x0_source step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    // lw x8 ; add x9,x8,x8 while a branch resolves taken in EX
    task automatic test_branch_over_load_use();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(S(1, 1, 0, 8, 1, 1, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        st.push_back(S(1, 8, 8, 9, 1, 0, 1, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 1, 1, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 1));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            scoreboard.push_back(ex[i]);
            @(negedge clk);
            got  = observe();
            want = scoreboard.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL branch_flush step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    // add x5 ; sub x6,x5,x7 ; memory busy three cycles with the MEM forward live
    task automatic test_mem_busy();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got;
        exp_t  want;
        st.push_back(S(1, 1, 2, 5, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 1));
        st.push_back(S(1, 5, 7, 6, 1, 0, 0, 0)); ex.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 1));
        for (int k = 0; k < 3; k++) begin
            st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E(2'b01, 2'b00, 1, 1, 0, 0, 1, 1));
        end
        st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E(2'b01, 2'b00, 0, 0, 0, 0, 1, 1));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            scoreboard.push_back(ex[i]);
            @(negedge clk);
            got  = observe();
            want = scoreboard.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("[TB] FAIL mem_busy step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    // Enter a load-use stall, turn it into a flush, then assert reset mid-cycle.
    task automatic test_reset_mid();
        exp_t got;
        exp_t want;
        applyStimulus(S(1, 1, 0, 8, 1, 1, 0, 0));
        scoreboard.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 1, 1));
        @(negedge clk);
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL mid_setup: got %h want %h", got, want);
        end
        applyStimulus(S(1, 8, 8, 9, 1, 0, 0, 0));
        scoreboard.push_back(E(2'b00, 2'b00, 1, 1, 0, 1, 1, 1));
        @(negedge clk);
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL mid_stall: got %h want %h", got, want);
        end
        ex_branch_taken = 1'b1;
        scoreboard.push_back(E(2'b00, 2'b00, 0, 0, 1, 1, 1, 1));
        #1;
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL mid_flush: got %h want %h", got, want);
        end
        #1;
        rst_n = 1'b0;
        scoreboard.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        #1;
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_async: got %h want %h", got, want);
        end
        @(negedge clk);
        rst_n           = 1'b1;
        ex_branch_taken = 1'b0;
        applyStimulus(S(1, 8, 8, 9, 1, 0, 0, 0));
        scoreboard.push_back(E(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        got  = observe();
        want = scoreboard.pop_front();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL after_release: got %h want %h", got, want);
        end
    endtask

    // Scenario sequence; idle gaps drain the shadow pipeline between scenarios.
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        idle(4);
        test_back_to_back();
        idle(4);
        test_load_use();
        idle(4);
        test_double_match();
        idle(4);
        test_x0();
        idle(4);
        test_branch_over_load_use();
        idle(4);
        test_mem_busy();
        idle(4);
        test_reset_mid();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
